rst_seq_gen: RTL

Reset generator and sequencer that drives the `rst` inputs of the design's flip-flop domains. It takes the raw board reset, which is asynchronous and active-low, and asserts all domain resets immediately. Deassertion is synchronized to `clk`, stretched, and then released one domain at a time in index order. It also accepts a software reset request with a req/ack handshake and reports the cause of the last reset.

---
 rtl/rst_seq_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: reset generator and sequencer for the design's reset domains.
// Assertion is asynchronous on rst (active-low). Release is synchronized to clk,
// stretched, and then handed out one domain at a time in index order.
// Optional feature macro: RST_SEQ_SW_EN enables the software reset request/ack
// path and the software reset cause (2'b10). Without it, sw_req is ignored,
// sw_ack is 0 and rst_cause is always 2'b01.
module rst_seq_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int STEP        = 8,
    parameter int N_OUT       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_req,
    output logic             sw_ack,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             ready,
    output logic [1:0]       rst_cause
);

    localparam int MAXC = (STRETCH > STEP) ? STRETCH : STEP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0] CNT_MAX      = CW'(MAXC);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_SYNC,
        S_STRETCH,
        S_RELEASE,
`ifdef RST_SEQ_SW_EN
        S_RUN,
        S_SW_HOLD
`else
        S_RUN
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] syncChain_q, syncChain_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          relIdx_q, relIdx_d;
    logic [N_OUT-1:0]       rstNOut_q, rstNOut_d;
    logic                   ready_q, ready_d;

`ifdef RST_SEQ_SW_EN
    logic                   swAck_q, swAck_d;
    logic [1:0]             cause_q, cause_d;
    logic                   armed_q, armed_d;

    assign sw_ack    = swAck_q;
    assign rst_cause = cause_q;
`else
    logic unused_swReq;

    assign unused_swReq = sw_req;
    assign sw_ack       = 1'b0;
    assign rst_cause    = 2'b01;
`endif

    assign rst_n_out = rstNOut_q;
    assign ready     = ready_q;

    // Next-state logic: the sync chain always shifts in a 1, the counter
    // saturates and is reloaded to 0 whenever the sequence moves on, and the
    // release bits accumulate so that a released domain stays released.
    always_comb begin
        state_d     = state_q;
        syncChain_d = {syncChain_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        relIdx_d    = relIdx_q;
        rstNOut_d   = rstNOut_q;
        ready_d     = ready_q;
`ifdef RST_SEQ_SW_EN
        swAck_d     = 1'b0;
        cause_d     = cause_q;
        armed_d     = armed_q;
`endif

        case (state_q)
            S_ASSERT: begin
                state_d = S_SYNC;
                cnt_d   = '0;
            end
            S_SYNC: begin
                if (syncChain_d[SYNC_STAGES-1]) begin
                    state_d = S_STRETCH;
                    cnt_d   = '0;
                end
            end
            S_STRETCH: begin
                if (cnt_q == STRETCH_LAST && syncChain_q[SYNC_STAGES-1]) begin
                    state_d      = S_RELEASE;
                    cnt_d        = '0;
                    relIdx_d     = '0;
                    rstNOut_d[0] = 1'b1;
                end
            end
            S_RELEASE: begin
                if (relIdx_q == IDX_LAST) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
`ifdef RST_SEQ_SW_EN
                    swAck_d = (cause_q == 2'b10);
`endif
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d               = '0;
                    relIdx_d            = relIdx_q + IW'(1);
                    rstNOut_d[relIdx_d] = 1'b1;
                end
            end
            S_RUN: begin
`ifdef RST_SEQ_SW_EN
                if (sw_req && armed_q) begin
                    state_d   = S_SW_HOLD;
                    cnt_d     = '0;
                    rstNOut_d = '0;
                    ready_d   = 1'b0;
                    cause_d   = 2'b10;
                    armed_d   = 1'b0;
                end else if (!sw_req) begin
                    armed_d = 1'b1;
                end
`endif
            end
`ifdef RST_SEQ_SW_EN
            S_SW_HOLD: begin
                if (cnt_q == STRETCH_LAST) begin
                    state_d      = S_RELEASE;
                    cnt_d        = '0;
                    relIdx_d     = '0;
                    rstNOut_d[0] = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_ASSERT;
            end
        endcase
    end

    // State register: rst low forces every output into reset immediately and
    // independently of the clock; only releases go through the clocked path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ASSERT;
            syncChain_q <= '0;
            cnt_q       <= '0;
            relIdx_q    <= '0;
            rstNOut_q   <= '0;
            ready_q     <= 1'b0;
`ifdef RST_SEQ_SW_EN
            swAck_q     <= 1'b0;
            cause_q     <= 2'b01;
            armed_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            syncChain_q <= syncChain_d;
            cnt_q       <= cnt_d;
            relIdx_q    <= relIdx_d;
            rstNOut_q   <= rstNOut_d;
            ready_q     <= ready_d;
`ifdef RST_SEQ_SW_EN
            swAck_q     <= swAck_d;
            cause_q     <= cause_d;
            armed_q     <= armed_d;
`endif
        end
    end

endmodule
